alu_cmd_issuer: RTL

ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

---
 rtl/alu_cmd_issuer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: accepts single-bit ALU commands, holds them on an external
// ALU for SETTLE_CYCLES cycles, and queues the captured results in a
// 2-entry in-order buffer. Divide/modulo by zero bypasses the ALU.
module alu_cmd_issuer #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_op,
   input  logic       cmd_a,
   input  logic       cmd_b,
   output logic [1:0] alu_in,
   output logic [3:0] alu_st,
   input  logic [4:0] alu_out,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [4:0] rsp_data,
   output logic       rsp_err,
   output logic       busy,
   output logic [7:0] op_count
);

   localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

   typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} state_t;

   state_t     state_reg, state_next;
   logic       ready_en_reg;
   logic [3:0] op_reg;
   logic       a_reg, b_reg;
   logic [3:0] settle_reg;
   logic [7:0] op_count_reg;

   logic [4:0] data_reg [2];
   logic       err_reg  [2];
   logic       rd_ptr_reg, wr_ptr_reg;
   logic [1:0] count_reg;

   logic       accept, div_zero, drive_done;
   logic       push, pop, push_err;
   logic [4:0] push_data;

   assign accept     = cmd_valid && cmd_ready;
   assign div_zero   = ((cmd_op == 4'b0110) || (cmd_op == 4'b0111)) && !cmd_b;
   assign drive_done = (state_reg == DRIVE) && (settle_reg == 4'd1);
   assign push_err   = accept && div_zero;
   assign push       = push_err || drive_done;
   assign push_data  = drive_done ? alu_out : 5'd0;
   assign pop        = rsp_ready && (count_reg != 2'd0);

   // Gate cmd_ready until the first clock edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ready_en_reg <= 1'b0;
      else        ready_en_reg <= 1'b1;
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // FSM next state: normal commands enter DRIVE, leave when settle count expires
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept && !div_zero) state_next = DRIVE;
         DRIVE:   if (settle_reg == 4'd1)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs: ALU drive only in DRIVE, handshake only in IDLE with buffer room
   always_comb begin
      busy      = (state_reg == DRIVE);
      alu_in    = 2'b00;
      alu_st    = 4'b0000;
      cmd_ready = ready_en_reg && (state_reg == IDLE) && (count_reg < 2'd2);
      if (state_reg == DRIVE) begin
         alu_in = {b_reg, a_reg};
         alu_st = op_reg;
      end
   end

   // Command capture, settle countdown and accepted-command counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_reg       <= 4'd0;
         a_reg        <= 1'b0;
         b_reg        <= 1'b0;
         settle_reg   <= 4'd0;
         op_count_reg <= 8'd0;
      end else begin
         if (accept) op_count_reg <= op_count_reg + 8'd1;
         if (accept && !div_zero) begin
            op_reg     <= cmd_op;
            a_reg      <= cmd_a;
            b_reg      <= cmd_b;
            settle_reg <= SETTLE_INIT;
         end else if (state_reg == DRIVE) begin
            settle_reg <= settle_reg - 4'd1;
         end
      end
   end

   // Result buffer: two slots, write/read pointers toggle, count tracks occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            data_reg[i] <= 5'd0;
            err_reg[i]  <= 1'b0;
         end
         rd_ptr_reg <= 1'b0;
         wr_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (push) begin
            data_reg[wr_ptr_reg] <= push_data;
            err_reg[wr_ptr_reg]  <= push_err;
            wr_ptr_reg           <= ~wr_ptr_reg;
         end
         if (pop) rd_ptr_reg <= ~rd_ptr_reg;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign rsp_valid = (count_reg != 2'd0);
   assign rsp_data  = rsp_valid ? data_reg[rd_ptr_reg] : 5'd0;
   assign rsp_err   = rsp_valid ? err_reg[rd_ptr_reg] : 1'b0;
   assign op_count  = op_count_reg;

endmodule
